screen_sequencer: RTL and testbench

Frame-synchronous controller that decides which screen layer drives the snake VGA pipeline: intro, game, pause or game-over.
- Consumes ASCII key events (keyboard/UART decoder) and the snake collision flag.
- Applies every screen change only at a frame boundary (vsync rising edge), so no frame tears.
- Generates game_start/run control and the difficulty-dependent snake move tick for the game logic.

---
 rtl/screen_pkg.sv | 45 ++++
 rtl/screen_sequencer_move_tick_gen.sv | 65 ++++++
 rtl/screen_sequencer.sv | 170 +++++++++++++++++
 tb/tb_screen_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : screen_pkg
//  Description : Screen states, screen_sel codes and key constants for the
//                snake screen sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package screen_pkg;

    typedef enum logic [1:0] {
        ST_INTRO     = 2'd0,
        ST_PLAYING   = 2'd1,
        ST_PAUSED    = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    localparam logic [1:0] SEL_INTRO = 2'b00;
    localparam logic [1:0] SEL_GAME  = 2'b01;
    localparam logic [1:0] SEL_PAUSE = 2'b10;
    localparam logic [1:0] SEL_OVER  = 2'b11;

    localparam logic [7:0] KEY_1     = 8'h31;
    localparam logic [7:0] KEY_2     = 8'h32;
    localparam logic [7:0] KEY_3     = 8'h33;
    localparam logic [7:0] KEY_4     = 8'h34;
    localparam logic [7:0] KEY_ENTER = 8'h0d;
    localparam logic [7:0] KEY_ESC   = 8'h1b;

    function automatic logic [1:0] sel_of(input state_t s);
        logic [1:0] sel;
        case (s)
            ST_INTRO:     sel = SEL_INTRO;
            ST_PLAYING:   sel = SEL_GAME;
            ST_PAUSED:    sel = SEL_PAUSE;
            default:      sel = SEL_OVER;
        endcase
        return sel;
    endfunction

    function automatic logic is_level_key(input logic [7:0] code);
        return (code >= KEY_1) && (code <= KEY_4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/screen_sequencer_move_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : move_tick_gen
//  Description : Frame divider producing the level-dependent snake move tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module move_tick_gen #(
    parameter int FRAMES_L1 = 12,
    parameter int FRAMES_L2 = 8,
    parameter int FRAMES_L3 = 5,
    parameter int FRAMES_L4 = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic [1:0] level,
    output logic       move_tick
);

    localparam int MAX_12     = (FRAMES_L1 > FRAMES_L2) ? FRAMES_L1 : FRAMES_L2;
    localparam int MAX_34     = (FRAMES_L3 > FRAMES_L4) ? FRAMES_L3 : FRAMES_L4;
    localparam int MAX_FRAMES = (MAX_12 > MAX_34) ? MAX_12 : MAX_34;
    localparam int DIV_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] period_m1;
    logic             tick_q, tick_d;

    always_comb begin
        case (level)
            2'd0:    period_m1 = DIV_W'(FRAMES_L1 - 1);
            2'd1:    period_m1 = DIV_W'(FRAMES_L2 - 1);
            2'd2:    period_m1 = DIV_W'(FRAMES_L3 - 1);
            default: period_m1 = DIV_W'(FRAMES_L4 - 1);
        endcase

        div_d  = div_q;
        tick_d = 1'b0;
        if (clear) begin
            div_d = '0;
        end else if (enable) begin
            if (div_q == period_m1) begin
                div_d  = '0;
                tick_d = 1'b1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign move_tick = tick_q;

endmodule
`default_nettype wire

// File: rtl/screen_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : screen_sequencer
//  Description : Frame-synchronous intro/game/pause/game-over screen control
//                with key capture, collision latch and move tick generation.
//  Revision    : 1.0 - initial release
// ============================================================================
module screen_sequencer
    import screen_pkg::*;
#(
    parameter int FRAMES_L1     = 12,
    parameter int FRAMES_L2     = 8,
    parameter int FRAMES_L3     = 5,
    parameter int FRAMES_L4     = 3,
    parameter int GAMEOVER_HOLD = 180
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync_in,
    input  logic [7:0] key_code,
    input  logic       key_valid,
    input  logic       collision,
    output logic [1:0] screen_sel,
    output logic       game_start,
    output logic       game_run,
    output logic       move_tick,
    output logic [1:0] level
);

    localparam int HOLD_W = (GAMEOVER_HOLD > 1) ? $clog2(GAMEOVER_HOLD) : 1;

    state_t            state_q, state_d;
    logic              vs_q;
    logic              pend_v_q, pend_v_d;
    logic [7:0]        pend_code_q, pend_code_d;
    logic              coll_q, coll_d;
    logic [1:0]        level_q, level_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [1:0]        screen_sel_q, screen_sel_d;
    logic              game_run_q, game_run_d;
    logic              game_start_q, game_start_d;

    logic              frame_start;
    logic              key_act;
    logic [7:0]        level_off;
    logic              div_clear;
    logic              div_en;

    always_comb begin
        frame_start  = vsync_in & ~vs_q;
        // Only the key captured before this boundary is acted on.
        key_act      = frame_start & pend_v_q;
        level_off    = pend_code_q - KEY_1;

        state_d      = state_q;
        level_d      = level_q;
        hold_d       = hold_q;
        game_start_d = 1'b0;
        div_clear    = 1'b0;

        if (frame_start) begin
            case (state_q)
                ST_INTRO: begin
                    if (key_act && is_level_key(pend_code_q)) begin
                        level_d = level_off[1:0];
                    end else if (key_act && pend_code_q == KEY_ENTER) begin
                        state_d      = ST_PLAYING;
                        game_start_d = 1'b1;
                        div_clear    = 1'b1;
                    end
                end
                ST_PLAYING: begin
                    if (coll_q) begin
                        state_d = ST_GAME_OVER;
                        hold_d  = '0;
                    end else if (key_act && pend_code_q == KEY_ESC) begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (key_act && pend_code_q == KEY_ENTER) begin
                        state_d = ST_PLAYING;
                    end else if (key_act && pend_code_q == KEY_ESC) begin
                        state_d = ST_INTRO;
                    end
                end
                default: begin
                    if (key_act && pend_code_q == KEY_ENTER) begin
                        state_d = ST_INTRO;
                    end else if (hold_q == HOLD_W'(GAMEOVER_HOLD - 1)) begin
                        state_d = ST_INTRO;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            endcase
        end

        div_en = frame_start && (state_q == ST_PLAYING) && (state_d == ST_PLAYING);

        pend_v_d    = pend_v_q;
        pend_code_d = pend_code_q;
        if (frame_start) begin
            pend_v_d = 1'b0;
        end
        if (key_valid) begin
            pend_v_d    = 1'b1;
            pend_code_d = key_code;
        end

        // A collision on the boundary cycle survives into the next frame.
        if (frame_start) begin
            coll_d = collision && (state_q == ST_PLAYING) && (state_d == ST_PLAYING);
        end else if (state_q != ST_PLAYING) begin
            coll_d = 1'b0;
        end else begin
            coll_d = coll_q | collision;
        end

        screen_sel_d = sel_of(state_d);
        game_run_d   = (state_d == ST_PLAYING);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INTRO;
            vs_q         <= 1'b0;
            pend_v_q     <= 1'b0;
            pend_code_q  <= 8'h00;
            coll_q       <= 1'b0;
            level_q      <= 2'd0;
            hold_q       <= '0;
            screen_sel_q <= SEL_INTRO;
            game_run_q   <= 1'b0;
            game_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_q         <= vsync_in;
            pend_v_q     <= pend_v_d;
            pend_code_q  <= pend_code_d;
            coll_q       <= coll_d;
            level_q      <= level_d;
            hold_q       <= hold_d;
            screen_sel_q <= screen_sel_d;
            game_run_q   <= game_run_d;
            game_start_q <= game_start_d;
        end
    end

    move_tick_gen #(
        .FRAMES_L1 (FRAMES_L1),
        .FRAMES_L2 (FRAMES_L2),
        .FRAMES_L3 (FRAMES_L3),
        .FRAMES_L4 (FRAMES_L4)
    ) u_move_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .clear     (div_clear),
        .enable    (div_en),
        .level     (level_q),
        .move_tick (move_tick)
    );

    assign screen_sel = screen_sel_q;
    assign game_run   = game_run_q;
    assign game_start = game_start_q;
    assign level      = level_q;

endmodule
`default_nettype wire

// File: tb/tb_screen_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_screen_sequencer
//  Description : Frame-level scoreboard bench for screen_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_screen_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       vsync_in;
    logic [7:0] key_code;
    logic       key_valid;
    logic       collision;
    logic [1:0] screen_sel;
    logic       game_start;
    logic       game_run;
    logic       move_tick;
    logic [1:0] level;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string      tag;
        logic [1:0] sel;
        logic       run;
        logic [1:0] lvl;
        logic       start;
        logic       tick;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    screen_sequencer u_dut (
        .clk        (clk),
        .rst        (rst),
        .vsync_in   (vsync_in),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .collision  (collision),
        .screen_sel (screen_sel),
        .game_start (game_start),
        .game_run   (game_run),
        .move_tick  (move_tick),
        .level      (level)
    );

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_key(input logic [7:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic pulse_collision();
        @(negedge clk);
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
    endtask

    // One vsync rise; expected outputs at N+1 are queued before driving.
    task automatic frame(input string tag, input logic [1:0] sel, input logic run,
                         input logic [1:0] lvl, input logic start, input logic tick,
                         input logic key_en = 1'b0, input logic [7:0] key = 8'h00,
                         input logic do_rst = 1'b0);
        exp_t e;
        sb.push_back('{tag: tag, sel: sel, run: run, lvl: lvl, start: start, tick: tick});
        @(negedge clk);
        vsync_in = 1'b1;
        if (key_en) begin
            key_valid = 1'b1;
            key_code  = key;
        end
        if (do_rst) rst = 1'b1;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_val({e.tag, ".sel"},   {6'd0, screen_sel}, {6'd0, e.sel});
        check_val({e.tag, ".run"},   {7'd0, game_run},   {7'd0, e.run});
        check_val({e.tag, ".level"}, {6'd0, level},      {6'd0, e.lvl});
        check_val({e.tag, ".start"}, {7'd0, game_start}, {7'd0, e.start});
        check_val({e.tag, ".tick"},  {7'd0, move_tick},  {7'd0, e.tick});
        @(negedge clk);
        key_valid = 1'b0;
        rst       = 1'b0;
        @(posedge clk);
        #1;
        check_val({e.tag, ".start_end"}, {7'd0, game_start}, 8'd0);
        check_val({e.tag, ".tick_end"},  {7'd0, move_tick},  8'd0);
        @(negedge clk);
        vsync_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        vsync_in  = 1'b0;
        key_code  = 8'h00;
        key_valid = 1'b0;
        collision = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("rst.sel",   {6'd0, screen_sel}, 8'd0);
        check_val("rst.run",   {7'd0, game_run},   8'd0);
        check_val("rst.level", {6'd0, level},      8'd0);
        check_val("rst.start", {7'd0, game_start}, 8'd0);
        check_val("rst.tick",  {7'd0, move_tick},  8'd0);

        for (int k = 0; k < 3; k++) frame("idle", 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);

        // '3' then ENTER in one frame: ENTER overwrites, level stays 0
        send_key(8'h33);
        send_key(8'h0d);
        frame("latest_wins", 2'b01, 1'b1, 2'd0, 1'b1, 1'b0);
        send_key(8'h1b);
        frame("esc_pause0", 2'b10, 1'b0, 2'd0, 1'b0, 1'b0);
        send_key(8'h1b);
        frame("esc_intro", 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);

        send_key(8'h33);
        frame("level3", 2'b00, 1'b0, 2'd2, 1'b0, 1'b0);
        send_key(8'h0d);
        frame("start", 2'b01, 1'b1, 2'd2, 1'b1, 1'b0);
        for (int k = 1; k <= 7; k++)
            frame($sformatf("play_f%0d", k), 2'b01, 1'b1, 2'd2, 1'b0, (k % 5) == 0);

        // divider now holds 2
        send_key(8'h1b);
        frame("pause", 2'b10, 1'b0, 2'd2, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) frame("paused", 2'b10, 1'b0, 2'd2, 1'b0, 1'b0);
        send_key(8'h0d);
        frame("resume", 2'b01, 1'b1, 2'd2, 1'b0, 1'b0);
        send_key(8'h31);
        for (int j = 1; j <= 8; j++)
            frame($sformatf("resume_f%0d", j), 2'b01, 1'b1, 2'd2, 1'b0, (j == 3) || (j == 8));

        pulse_collision();
        send_key(8'h1b);
        frame("coll_over_esc", 2'b11, 1'b0, 2'd2, 1'b0, 1'b0);
        for (int k = 1; k <= 180; k++)
            frame($sformatf("hold_f%0d", k), (k == 180) ? 2'b00 : 2'b11, 1'b0, 2'd2, 1'b0, 1'b0);

        frame("key_on_vsync", 2'b00, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 8'h0d);
        frame("deferred_start", 2'b01, 1'b1, 2'd2, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++)
            frame($sformatf("pre_rst_f%0d", k), 2'b01, 1'b1, 2'd2, 1'b0, 1'b0);
        frame("rst_on_tick", 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        frame("after_rst", 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
